// File: rtl/seg7_scan_ctrl.sv
// Three-digit seven-segment front end. It captures an 8-bit product, hands it
// to the external binary-to-BCD converter, latches the returned digits, and
// time-multiplexes them onto one shared decoder with leading-zero blanking.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for a new product; i_data is captured on handshake
// CONV  | converter settles from o_bcd_data; digits are latched on exit
module seg7_scan_ctrl #(
  parameter int REFRESH_DIV   = 50000,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [7:0] i_data,
  output logic [7:0] o_bcd_data,
  input  logic [3:0] i_units,
  input  logic [3:0] i_tens,
  input  logic [3:0] i_hunds,
  output logic [2:0] o_digit_sel,
  output logic [3:0] o_digit,
  output logic       o_blank,
  output logic       o_err
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0] SEL_OFF   = AN_ACTIVE_LOW ? 3'b111 : 3'b000;
  localparam logic [2:0] SEL_UNITS = AN_ACTIVE_LOW ? 3'b110 : 3'b001;

  typedef enum logic {ST_IDLE, ST_CONV} state_t;
  typedef enum logic [1:0] {SLOT_UNITS, SLOT_TENS, SLOT_HUNDS} slot_t;

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic [7:0]      bcd_data_q, bcd_data_d;
  logic [3:0]      units_q, units_d, tens_q, tens_d, hunds_q, hunds_d;
  logic            err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_t           slot_q, slot_d;
  logic [2:0]      sel_q, sel_d;
  logic [3:0]      digit_q, digit_d;
  logic            blank_q, blank_d;

  logic [2:0]      onehot;

  // Handshake FSM: capture the operand, then latch converter digits one cycle later
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    bcd_data_d = bcd_data_q;
    units_d    = units_q;
    tens_d     = tens_q;
    hunds_d    = hunds_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          bcd_data_d = i_data;
          ready_d    = 1'b0;
          state_d    = ST_CONV;
        end
      end
      ST_CONV: begin
        units_d = i_units;
        tens_d  = i_tens;
        hunds_d = i_hunds;
        // digits are kept even when illegal so the bad value stays visible
        err_d   = (i_units > 4'd9) || (i_tens > 4'd9) || (i_hunds > 4'd2);
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Free-running scan counter; the slot rotates units -> tens -> hunds on wrap
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    slot_d = slot_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      case (slot_q)
        SLOT_UNITS: slot_d = SLOT_TENS;
        SLOT_TENS:  slot_d = SLOT_HUNDS;
        default:    slot_d = SLOT_UNITS;
      endcase
    end
  end

  // Slot outputs are built from next-state slot and digits so they change on
  // the same edge as either source, and a scan never mixes old and new digits
  always_comb begin
    onehot  = 3'b001;
    blank_d = 1'b0;
    digit_d = units_d;
    case (slot_d)
      SLOT_TENS: begin
        onehot  = 3'b010;
        blank_d = (hunds_d == 4'd0) && (tens_d == 4'd0);
        digit_d = tens_d;
      end
      SLOT_HUNDS: begin
        onehot  = 3'b100;
        blank_d = (hunds_d == 4'd0);
        digit_d = hunds_d;
      end
      default: begin
        onehot  = 3'b001;
        blank_d = 1'b0;
        digit_d = units_d;
      end
    endcase
    if (blank_d) begin
      sel_d   = SEL_OFF;
      digit_d = 4'd0;
    end else begin
      sel_d = AN_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      bcd_data_q <= 8'd0;
      units_q    <= 4'd0;
      tens_q     <= 4'd0;
      hunds_q    <= 4'd0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      slot_q     <= SLOT_UNITS;
      sel_q      <= SEL_UNITS;
      digit_q    <= 4'd0;
      blank_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      bcd_data_q <= bcd_data_d;
      units_q    <= units_d;
      tens_q     <= tens_d;
      hunds_q    <= hunds_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      sel_q      <= sel_d;
      digit_q    <= digit_d;
      blank_q    <= blank_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_bcd_data  = bcd_data_q;
  assign o_digit_sel = sel_q;
  assign o_digit     = digit_q;
  assign o_blank     = blank_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with REFRESH_DIV = 4, active-low anodes.
module tb_seg7_scan_ctrl;

  localparam int RD = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_data = 8'd0;
  logic [7:0] o_bcd_data;
  logic [3:0] i_units, i_tens, i_hunds;
  logic [2:0] o_digit_sel;
  logic [3:0] o_digit;
  logic       o_blank;
  logic       o_err;

  logic       force_a = 1'b0;
  int         n_chk = 0;
  int         n_pass = 0;

  // expected scan position and latched digits
  int         m_cnt, m_slot;
  logic [3:0] m_u = 4'd0, m_t = 4'd0, m_h = 4'd0;

  seg7_scan_ctrl #(.REFRESH_DIV(RD), .AN_ACTIVE_LOW(1'b1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_bcd_data(o_bcd_data), .i_units(i_units),
    .i_tens(i_tens), .i_hunds(i_hunds), .o_digit_sel(o_digit_sel),
    .o_digit(o_digit), .o_blank(o_blank), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  // converter model, with an optional illegal tens digit
  always_comb begin
    i_units = 4'(o_bcd_data % 8'd10);
    i_tens  = 4'((o_bcd_data / 8'd10) % 8'd10);
    i_hunds = 4'(o_bcd_data / 8'd100);
    if (force_a) i_tens = 4'hA;
  end

  // scan position model
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_cnt  <= 0;
      m_slot <= 0;
    end else if (m_cnt == RD - 1) begin
      m_cnt  <= 0;
      m_slot <= (m_slot == 2) ? 0 : m_slot + 1;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_display(input string tag);
    logic       blk;
    logic [2:0] sel;
    logic [3:0] dig;
    blk = (m_slot == 2 && m_h == 4'd0) || (m_slot == 1 && m_h == 4'd0 && m_t == 4'd0);
    sel = blk ? 3'b111 : ~(3'b001 << m_slot);
    dig = blk ? 4'd0 : (m_slot == 0) ? m_u : (m_slot == 1) ? m_t : m_h;
    check({tag, "_sel"}, 32'(o_digit_sel), 32'(sel));
    check({tag, "_digit"}, 32'(o_digit), 32'(dig));
    check({tag, "_blank"}, 32'(o_blank), 32'(blk));
  endtask

  task automatic scan(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check_display(tag);
      tick();
    end
  endtask

  task automatic send(input logic [7:0] v, input logic [3:0] u, input logic [3:0] t,
                      input logic [3:0] h, input logic exp_err);
    int k;
    i_valid = 1'b1;
    i_data  = v;
    k = 0;
    while (!o_ready && k < 10) begin
      tick();
      k++;
    end
    check("ready_wait", 32'(o_ready), 32'd1);
    tick();
    check("ready_low", 32'(o_ready), 32'd0);
    check("bcd_data", 32'(o_bcd_data), 32'(v));
    i_valid = 1'b0;
    tick();
    check("ready_back", 32'(o_ready), 32'd1);
    m_u = u; m_t = t; m_h = h;
    check("err", 32'(o_err), 32'(exp_err));
    check_display("latch");
  endtask

  initial begin
    int cnt_units;
    #12;
    // reset values, display shows "0"
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_sel", 32'(o_digit_sel), 32'h6);
    check("rst_digit", 32'(o_digit), 32'd0);
    check("rst_blank", 32'(o_blank), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_bcd", 32'(o_bcd_data), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    scan("idle0", 3 * 3 * RD);

    // 255 -> 2 5 5, no blanking, each slot 4 cycles
    send(8'd255, 4'd5, 4'd5, 4'd2, 1'b0);
    cnt_units = 0;
    for (int i = 0; i < 3 * RD; i++) begin
      check_display("d255");
      if (o_digit_sel == 3'b110) cnt_units++;
      tick();
    end
    check("units_slot_len", 32'(cnt_units), 32'(RD));

    // 7 -> tens and hunds blanked
    send(8'd7, 4'd7, 4'd0, 4'd0, 1'b0);
    scan("d7", 3 * RD + 1);
    // 40 -> hunds blanked, 4 0 shown
    send(8'd40, 4'd0, 4'd4, 4'd0, 1'b0);
    scan("d40", 3 * RD + 1);

    // back-to-back with valid held high; CONV-cycle data is not captured
    i_valid = 1'b1; i_data = 8'd10;
    check("b2b_ready0", 32'(o_ready), 32'd1);
    tick();
    check("b2b_ready1", 32'(o_ready), 32'd0);
    check("b2b_bcd10", 32'(o_bcd_data), 32'd10);
    i_data = 8'd20;
    tick();
    check("b2b_ready2", 32'(o_ready), 32'd1);
    check("b2b_bcd_hold", 32'(o_bcd_data), 32'd10);
    m_u = 4'd0; m_t = 4'd1; m_h = 4'd0;
    check_display("b2b10");
    tick();
    check("b2b_ready3", 32'(o_ready), 32'd0);
    check("b2b_bcd20", 32'(o_bcd_data), 32'd20);
    i_data = 8'd30;
    tick();
    check("b2b_ready4", 32'(o_ready), 32'd1);
    m_t = 4'd2;
    check_display("b2b20");
    tick();
    check("b2b_ready5", 32'(o_ready), 32'd0);
    check("b2b_bcd30", 32'(o_bcd_data), 32'd30);
    i_valid = 1'b0;
    tick();
    m_t = 4'd3;
    check_display("b2b30");
    tick();
    check("b2b_idle", 32'(o_ready), 32'd1);
    check("b2b_noacc", 32'(o_bcd_data), 32'd30);

    // illegal converter tens digit sets the sticky error; legal value clears it
    force_a = 1'b1;
    send(8'd50, 4'd0, 4'hA, 4'd0, 1'b1);
    scan("err50", 3 * RD);
    check("err_hold", 32'(o_err), 32'd1);
    force_a = 1'b0;
    send(8'd12, 4'd2, 4'd1, 4'd0, 1'b0);
    scan("d12", RD);
    force_a = 1'b1;
    send(8'd50, 4'd0, 4'hA, 4'd0, 1'b1);
    force_a = 1'b0;

    // reset in the middle of CONV for 99
    i_valid = 1'b1; i_data = 8'd99;
    tick();
    check("r_conv", 32'(o_ready), 32'd0);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    m_u = 4'd0; m_t = 4'd0; m_h = 4'd0;
    #1;
    check("r_ready", 32'(o_ready), 32'd1);
    check("r_bcd", 32'(o_bcd_data), 32'd0);
    check("r_sel", 32'(o_digit_sel), 32'h6);
    check("r_digit", 32'(o_digit), 32'd0);
    check("r_blank", 32'(o_blank), 32'd0);
    check("r_err", 32'(o_err), 32'd0);
    tick();
    check_display("r_hold");
    i_rst_n = 1'b1;
    tick();
    scan("r_after", 3 * RD);
    send(8'd3, 4'd3, 4'd0, 4'd0, 1'b0);
    scan("d3", 3 * RD);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
